uart_flow: RTL and testbench

- Parametrised UART transceiver with RTS/CTS hardware flow control and a buffered receive path.
- Next-generation serial front end for the HSM SoC top level. Drives the board-level tx/rts pins and receives rx/cts.
- Host side uses valid/ready byte streams. Replaces the fixed-format UART inside the SoC wrapper.
- Adds configurable bit timing, data width, RX FIFO depth, RTS watermark, framing-error and overrun reporting.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_flow.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_flow.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_flow serial front end.
// State encodings for both FSMs, plus the width helper used to size counters and pointers.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Ceiling log2, with a minimum of 1 so a signal of this width is never zero bits wide.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int half_bit(input int clkDiv);
    return clkDiv / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. A push into a full FIFO is accepted only when a pop happens in the same cycle.
// A pop from an empty FIFO is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_BITS-1:0]       push_data,
  input  logic                       pop,
  output logic [DATA_BITS-1:0]       head,
  output logic                       empty,
  output logic                       full,
  output logic [clog2(FIFO_DEPTH):0] count
);

  localparam int AW = clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wrPtr;
  logic [AW-1:0]        r_rdPtr;
  logic [CW-1:0]        r_count;
  logic                 w_popOk;
  logic                 w_pushOk;

  assign empty    = (r_count == '0);
  assign full     = (r_count == DEPTH_C);
  assign count    = r_count;
  assign head     = r_mem[r_rdPtr];
  assign w_popOk  = pop && !empty;
  assign w_pushOk = push && (!full || w_popOk);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_popOk)  r_rdPtr <= r_rdPtr + AW'(1);
      if (w_pushOk && !w_popOk)      r_count <= r_count + CW'(1);
      else if (!w_pushOk && w_popOk) r_count <= r_count - CW'(1);
    end
  end

  // Storage is not reset; the pointers and the count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wrPtr] <= push_data;
  end

endmodule

// File: rtl/uart_flow.sv
// UART transceiver with RTS/CTS flow control and a buffered receive path.
// tx and rts are driven from flops; rx and cts are used only after 2-flop synchronisation.
module uart_flow
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 cts,
  output logic                 tx,
  output logic                 rts,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int HALF_BIT = half_bit(CLK_DIV);
  localparam int CNT_W    = clog2(CLK_DIV);
  localparam int BW       = clog2(DATA_BITS);
  localparam int CW       = clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF_BIT - 1);
  localparam logic [BW-1:0]    IDX_LAST   = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0]    RTS_THRESH = CW'(FIFO_DEPTH - RTS_MARGIN);

  logic r_rxMeta, r_rxSync, r_ctsMeta, r_ctsSync;

  tx_state_t            r_txState;
  logic [CNT_W-1:0]     r_txCnt;
  logic [BW-1:0]        r_txIdx;
  logic [DATA_BITS-1:0] r_txShift;
  logic                 r_tx;
  logic                 w_txReady;

  rx_state_t            r_rxState;
  logic [CNT_W-1:0]     r_rxCnt;
  logic [BW-1:0]        r_rxIdx;
  logic [DATA_BITS-1:0] r_rxShift;
  logic                 r_frameErr;
  logic                 r_overrun;
  logic                 r_rts;

  logic                 w_push, w_popOk, w_pushOk;
  logic                 w_empty, w_full;
  logic [CW-1:0]        w_count, w_cntNext;

  // Synchronisers reset to the idle-high / not-clear level so neither FSM starts on a stale low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_ctsMeta <= 1'b1;
      r_ctsSync <= 1'b1;
    end else begin
      r_rxMeta  <= rx;
      r_rxSync  <= r_rxMeta;
      r_ctsMeta <= cts;
      r_ctsSync <= r_ctsMeta;
    end
  end

  assign w_txReady = (r_txState == TX_IDLE) && !r_ctsSync;
  assign tx_ready  = w_txReady;
  assign tx        = r_tx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txIdx   <= '0;
      r_txShift <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_txState)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (tx_valid && w_txReady) begin
            r_txShift <= tx_data;
            r_txCnt   <= '0;
            r_tx      <= 1'b0;
            r_txState <= TX_START;
          end
        end
        TX_START: begin
          if (r_txCnt == CNT_LAST) begin
            r_txCnt   <= '0;
            r_txIdx   <= '0;
            r_tx      <= r_txShift[0];
            r_txShift <= r_txShift >> 1;
            r_txState <= TX_DATA;
          end else begin
            r_txCnt <= r_txCnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (r_txCnt == CNT_LAST) begin
            r_txCnt <= '0;
            if (r_txIdx == IDX_LAST) begin
              r_tx      <= 1'b1;
              r_txState <= TX_STOP;
            end else begin
              r_txIdx   <= r_txIdx + BW'(1);
              r_tx      <= r_txShift[0];
              r_txShift <= r_txShift >> 1;
            end
          end else begin
            r_txCnt <= r_txCnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (r_txCnt == CNT_LAST) begin
            r_txCnt   <= '0;
            r_txState <= TX_IDLE;
          end else begin
            r_txCnt <= r_txCnt + CNT_W'(1);
          end
        end
        default: r_txState <= TX_IDLE;
      endcase
    end
  end

  // The start bit is re-checked at half a bit so later samples land mid-bit; a stop of 0 parks in WAIT_HIGH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxIdx    <= '0;
      r_rxShift  <= '0;
      r_frameErr <= 1'b0;
    end else begin
      r_frameErr <= 1'b0;
      case (r_rxState)
        RX_IDLE: begin
          if (!r_rxSync) begin
            r_rxCnt   <= '0;
            r_rxState <= RX_START;
          end
        end
        RX_START: begin
          if (r_rxCnt == CNT_HALF) begin
            r_rxCnt <= '0;
            r_rxIdx <= '0;
            r_rxState <= r_rxSync ? RX_IDLE : RX_DATA;
          end else begin
            r_rxCnt <= r_rxCnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rxCnt == CNT_LAST) begin
            r_rxCnt   <= '0;
            r_rxShift <= {r_rxSync, r_rxShift[DATA_BITS-1:1]};
            if (r_rxIdx == IDX_LAST) r_rxState <= RX_STOP;
            else                     r_rxIdx   <= r_rxIdx + BW'(1);
          end else begin
            r_rxCnt <= r_rxCnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rxCnt == CNT_LAST) begin
            r_rxCnt <= '0;
            if (r_rxSync) begin
              r_rxState <= RX_IDLE;
            end else begin
              r_frameErr <= 1'b1;
              r_rxState  <= RX_WAIT_HIGH;
            end
          end else begin
            r_rxCnt <= r_rxCnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rxSync) r_rxState <= RX_IDLE;
        end
        default: r_rxState <= RX_IDLE;
      endcase
    end
  end

  assign w_push    = (r_rxState == RX_STOP) && (r_rxCnt == CNT_LAST) && r_rxSync;
  assign w_popOk   = rx_ready && !w_empty;
  assign w_pushOk  = w_push && (!w_full || w_popOk);
  assign rx_valid  = !w_empty;
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;
  assign rts       = r_rts;

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (r_rxShift),
    .pop       (rx_ready),
    .head      (rx_data),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  always_comb begin
    w_cntNext = w_count;
    if (w_pushOk && !w_popOk)      w_cntNext = w_count + CW'(1);
    else if (!w_pushOk && w_popOk) w_cntNext = w_count - CW'(1);
  end

  // rts is computed from next-cycle occupancy so it moves on the same edge as the FIFO count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rts     <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_rts     <= (w_cntNext >= RTS_THRESH);
      r_overrun <= w_push && w_full && !w_popOk;
    end
  end

endmodule

// File: tb/tb_uart_flow.sv
// Self-checking bench for uart_flow at 4 clocks/bit, 8 data bits, a 4-entry FIFO and an rts threshold of 3.
// The reference model is the frame bit arithmetic plus a bounded byte queue for the receive side.
module tb_uart_flow;

  localparam int CLK_DIV    = 4;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int RTS_MARGIN = 1;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int THRESH     = FIFO_DEPTH - RTS_MARGIN;

  logic                 clk, reset, rx, cts;
  logic                 tx, rts, tx_ready, rx_valid, rx_ready, tx_valid;
  logic                 frame_err, overrun;
  logic [DATA_BITS-1:0] tx_data, rx_data;

  int passCount, failCount, checkCount;
  int feSeen, ovSeen, expFe, expOv;
  logic [DATA_BITS-1:0] model[$];

  uart_flow #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RTS_MARGIN (RTS_MARGIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .cts       (cts),
    .tx        (tx),
    .rts       (rts),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse outputs are tallied on the rising edge, which sees the value held through the previous cycle.
  always @(posedge clk) begin
    if (frame_err === 1'b1) feSeen++;
    if (overrun === 1'b1)   ovSeen++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frameBit(input logic [DATA_BITS-1:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == FRAME_BITS - 1) return 1'b1;
    return b[k-1];
  endfunction

  // Called on the first negedge after the handshake edge; optionally raises cts partway through.
  task automatic checkTxFrame(input logic [DATA_BITS-1:0] b, input int ctsRaiseAt);
    for (int k = 0; k < FRAME_BITS * CLK_DIV; k++) begin
      if (k == ctsRaiseAt) cts = 1'b1;
      checkOutput("txBit", tx, frameBit(b, k / CLK_DIV));
      checkOutput("txBusy", tx_ready, 0);
      @(negedge clk);
    end
    checkOutput("txIdleLine", tx, 1);
    checkOutput("txReadyAfter", tx_ready, (cts == 1'b0));
  endtask

  task automatic applyStimulusTx(input logic [DATA_BITS-1:0] b);
    int guard;
    tx_data  = b;
    tx_valid = 1'b1;
    guard    = 0;
    while (tx_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("txReadyWait", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    checkTxFrame(b, -1);
  endtask

  task automatic applyStimulusRx(input logic [DATA_BITS-1:0] b, input logic stopBit, input int lowTail);
    for (int k = 0; k < FRAME_BITS; k++) begin
      rx = (k == FRAME_BITS - 1) ? stopBit : frameBit(b, k);
      repeat (CLK_DIV) @(negedge clk);
    end
    if (!stopBit) begin
      rx = 1'b0;
      repeat (lowTail) @(negedge clk);
      expFe++;
    end else if (model.size() < FIFO_DEPTH) begin
      model.push_back(b);
    end else begin
      expOv++;
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic drainRx();
    logic [DATA_BITS-1:0] exp;
    while (model.size() > 0) begin
      checkOutput("rxValid", rx_valid, 1);
      exp = model.pop_front();
      checkOutput("rxData", rx_data, exp);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      checkOutput("rtsDrain", rts, (model.size() >= THRESH));
    end
    checkOutput("rxEmpty", rx_valid, 0);
  endtask

  initial begin
    logic [DATA_BITS-1:0] rb;
    int n;
    passCount = 0; failCount = 0; checkCount = 0;
    feSeen = 0; ovSeen = 0; expFe = 0; expOv = 0;
    reset = 1'b1; rx = 1'b1; cts = 1'b0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rstTx", tx, 1);
    checkOutput("rstRts", rts, 1);
    checkOutput("rstTxReady", tx_ready, 0);
    checkOutput("rstRxValid", rx_valid, 0);
    checkOutput("rstFrameErr", frame_err, 0);
    checkOutput("rstOverrun", overrun, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rtsAfterRst", rts, 0);

    $display("[TB] TX 0xA5 with cts low");
    applyStimulusTx(8'hA5);

    $display("[TB] TX held off by cts");
    cts = 1'b1;
    repeat (3) @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("ctsHoldTx", tx, 1);
      checkOutput("ctsHoldReady", tx_ready, 0);
    end
    cts = 1'b0;
    @(negedge clk);
    checkOutput("ctsSync1", tx_ready, 0);
    @(negedge clk);
    checkOutput("ctsSync2", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    checkTxFrame(8'h3C, 15);
    cts = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] RX 0x3C then a glitch");
    applyStimulusRx(8'h3C, 1'b1, 0);
    checkOutput("rx3cValid", rx_valid, 1);
    checkOutput("rx3cData", rx_data, 8'h3C);
    drainRx();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("glitchNoPush", rx_valid, 0);
    checkOutput("glitchNoFe", feSeen, expFe);

    $display("[TB] RX fill to overrun");
    for (int i = 1; i <= 5; i++) begin
      applyStimulusRx(DATA_BITS'(i), 1'b1, 0);
      checkOutput("rtsFill", rts, (model.size() >= THRESH));
    end
    checkOutput("overrunCount", ovSeen, expOv);
    drainRx();

    $display("[TB] RX bad stop bit and break");
    applyStimulusRx(DATA_BITS'($urandom), 1'b0, 20);
    checkOutput("breakFeCount", feSeen, expFe);
    checkOutput("breakEmpty", rx_valid, 0);
    applyStimulusRx(8'h55, 1'b1, 0);
    drainRx();

    $display("[TB] randomized traffic");
    for (int r = 0; r < 4; r++) begin
      applyStimulusTx(DATA_BITS'($urandom));
      n = $urandom_range(1, FIFO_DEPTH + 1);
      for (int i = 0; i < n; i++) begin
        rb = DATA_BITS'($urandom);
        applyStimulusRx(rb, ($urandom_range(0, 5) != 0), 3);
        checkOutput("rtsRand", rts, (model.size() >= THRESH));
      end
      checkOutput("randFe", feSeen, expFe);
      checkOutput("randOv", ovSeen, expOv);
      drainRx();
    end

    $display("[TB] reset mid-TX with bytes queued");
    applyStimulusRx(8'hA1, 1'b1, 0);
    applyStimulusRx(DATA_BITS'($urandom), 1'b1, 0);
    checkOutput("preRstRts", rts, 0);
    checkOutput("preRstValid", rx_valid, 1);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midTxLow", tx, 0);
    #2;
    reset = 1'b1;
    #1;
    model.delete();
    checkOutput("asyncRstTx", tx, 1);
    checkOutput("asyncRstRts", rts, 1);
    checkOutput("asyncRstValid", rx_valid, 0);
    checkOutput("asyncRstReady", tx_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("postRstRts", rts, 0);
    checkOutput("postRstValid", rx_valid, 0);
    applyStimulusTx(8'h00);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
